// File: rtl/mac_butterfly.sv
// Complex radix-2 butterfly / MAC in binary32: y0 = x0 + w0*x1, y1 = x0 + w1*x1.
// Eight truncating multipliers and eight adders feed one output register stage.

module fp_mul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] p
);
   logic [47:0]       prod;
   logic signed [9:0] e;
   logic              sgn;
   logic              unused_bits;

   always_comb begin
      p    = 32'h0;
      sgn  = a[31] ^ b[31];
      prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
             + (prod[47] ? 10'sd1 : 10'sd0);
      // Zero/denormal operands and underflow both yield +0.
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) p = 32'h0;
      else if (e <= 10'sd0)                     p = 32'h0;
      else if (e > 10'sd254)                    p = {sgn, 8'hFF, 23'h0};
      else p = {sgn, e[7:0], prod[47] ? prod[46:24] : prod[45:23]};
   end

   assign unused_bits = ^prod[22:0];
endmodule

module fp_add (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] s
);
   logic [31:0]       big, sml;
   logic [7:0]        diff;
   logic [25:0]       mb, ms, sh;
   logic [26:0]       sum;
   logic [4:0]        lz;
   logic              found;
   logic signed [9:0] e;
   logic [22:0]       mant;
   logic              za, zb;
   logic              unused_bits;

   always_comb begin
      s     = 32'h0;
      za    = (a[30:23] == 8'd0);
      zb    = (b[30:23] == 8'd0);
      big   = a;
      sml   = b;
      if (b[30:0] > a[30:0]) begin
         big = b;
         sml = a;
      end
      diff  = big[30:23] - sml[30:23];
      // Two extra low bits are kept during alignment, then dropped (truncation).
      mb    = {1'b1, big[22:0], 2'b00};
      ms    = (diff >= 8'd26) ? 26'd0 : ({1'b1, sml[22:0], 2'b00} >> diff);
      sum   = (big[31] ^ sml[31]) ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 25; i >= 0; i--) begin
         if (!found) begin
            if (sum[i]) found = 1'b1;
            else        lz    = lz + 5'd1;
         end
      end
      sh    = sum[25:0] << lz;
      if (sum[26]) begin
         e    = $signed({2'b00, big[30:23]}) + 10'sd1;
         mant = sum[25:3];
      end else begin
         e    = $signed({2'b00, big[30:23]}) - $signed({5'b00000, lz});
         mant = sh[24:2];
      end
      if (za && zb)            s = 32'h0;
      else if (za)             s = b;
      else if (zb)             s = a;
      else if (sum == 27'd0)   s = 32'h0;
      else if (e <= 10'sd0)    s = 32'h0;
      else if (e > 10'sd254)   s = {big[31], 8'hFF, 23'h0};
      else                     s = {big[31], e[7:0], mant};
   end

   assign unused_bits = ^{sh[25], sh[1:0]};
endmodule

module mac_butterfly (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] x0,
   input  logic [63:0] x1,
   input  logic [63:0] w0,
   input  logic [63:0] w1,
   output logic [63:0] y0,
   output logic [63:0] y1
);
   logic [1:0][63:0] w;
   logic [1:0][63:0] yc;

   assign w = {w1, w0};

   for (genvar k = 0; k < 2; k++) begin : g_out
      logic [31:0] p, q, r, s, t, u, re, im;

      fp_mul u_p  (.a(w[k][63:32]), .b(x1[63:32]), .p(p));
      fp_mul u_q  (.a(w[k][31:0]),  .b(x1[31:0]),  .p(q));
      fp_mul u_s  (.a(w[k][63:32]), .b(x1[31:0]),  .p(s));
      fp_mul u_t  (.a(w[k][31:0]),  .b(x1[63:32]), .p(t));
      // p - q is realised as p + (-q).
      fp_add u_r  (.a(p),          .b({~q[31], q[30:0]}), .s(r));
      fp_add u_re (.a(x0[63:32]),  .b(r),                 .s(re));
      fp_add u_u  (.a(s),          .b(t),                 .s(u));
      fp_add u_im (.a(x0[31:0]),   .b(u),                 .s(im));

      assign yc[k] = {re, im};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y0 <= 64'h0;
         y1 <= 64'h0;
      end else begin
         y0 <= yc[0];
         y1 <= yc[1];
      end
   end
endmodule

// File: tb/tb_mac_butterfly.sv
// Scoreboard bench for mac_butterfly: stimulus pushes expected results,
// a monitor pops and compares one edge later.

module tb_mac_butterfly;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] x0 = '0, x1 = '0, w0 = '0, w1 = '0;
   logic [63:0] y0, y1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [63:0] y0;
      logic [63:0] y1;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [63:0] P1 = 64'h3F800000_00000000;
   localparam logic [63:0] M1 = 64'hBF800000_00000000;

   mac_butterfly dut (
      .clk(clk), .reset(reset),
      .x0(x0), .x1(x1), .w0(w0), .w1(w1),
      .y0(y0), .y1(y1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] d,
                        input logic [63:0] e0, input logic [63:0] e1,
                        input string name);
      exp_t e;
      @(negedge clk);
      x0 = a; x1 = b; w0 = c; w1 = d;
      e.y0 = e0; e.y1 = e1; e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: every result must appear on the edge right after its inputs.
   exp_t m;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         m = exp_q.pop_front();
         chk({m.name, ".y0"}, y0, m.y0);
         chk({m.name, ".y1"}, y1, m.y1);
      end
   end

   initial begin
      x0 = P1; x1 = 64'h40000000_00000000; w0 = P1; w1 = M1;
      #3;
      chk("rst.y0", y0, 64'h0);
      chk("rst.y1", y1, 64'h0);
      @(posedge clk); #2 reset = 1'b1;
      drive(P1, 64'h40000000_00000000, P1, M1,
            64'h40400000_00000000, 64'hBF800000_00000000, "rel");
      drive(64'h0, 64'h3F800000_3F800000, 64'h00000000_3F800000, P1,
            64'hBF800000_3F800000, 64'h3F800000_3F800000, "cplx");
      drive(64'h40000000_00000000, 64'h40000000_00000000, P1, M1,
            64'h40800000_00000000, 64'h0, "cancel");
      // Streaming: a new sum/difference pair every cycle.
      drive(64'h3F800000_00000000, 64'h40A00000_00000000, P1, M1,
            64'h40C00000_00000000, 64'hC0800000_00000000, "strm0");
      drive(64'h40000000_00000000, 64'h40C00000_00000000, P1, M1,
            64'h41000000_00000000, 64'hC0800000_00000000, "strm1");
      drive(64'h40400000_00000000, 64'h40E00000_00000000, P1, M1,
            64'h41200000_00000000, 64'hC0800000_00000000, "strm2");
      drive(64'h40800000_00000000, 64'h41000000_00000000, P1, M1,
            64'h41400000_00000000, 64'hC0800000_00000000, "strm3");
      drive(P1, 64'h33800000_00000000, P1, M1,
            64'h3F800000_00000000, 64'h3F7FFFFF_00000000, "round");
      drive(64'h3F800000_40000000, 64'h40400000_40400000,
            64'h40000000_00000000, 64'h00000000_40000000,
            64'h40E00000_41000000, 64'hC0A00000_41000000, "wmix");
      drive(64'h0, 64'h40400000_00000000, 64'h40400000_00000000, 64'hC0400000_00000000,
            64'h41100000_00000000, 64'hC1100000_00000000, "mulnorm");
      drive(64'h0, 64'h7F000000_00000000, 64'h40000000_00000000, M1,
            64'h7F800000_00000000, 64'hFF000000_00000000, "ovf");
      drive(64'h00400000_00000000, P1, P1, M1,
            P1, M1, "denorm");
      // Mid-stream reset asserted between edges.
      drive(64'h40000000_00000000, 64'h40000000_00000000, P1, M1,
            64'h40800000_00000000, 64'h0, "pre_mid");
      @(posedge clk); #3 reset = 1'b0;
      #1;
      chk("mid.y0", y0, 64'h0);
      chk("mid.y1", y1, 64'h0);
      @(posedge clk); #1;
      chk("hold.y0", y0, 64'h0);
      chk("hold.y1", y1, 64'h0);
      #2 reset = 1'b1;
      #1;
      chk("relwait.y0", y0, 64'h0);
      drive(64'h40400000_00000000, P1, P1, M1,
            64'h40800000_00000000, 64'h40000000_00000000, "post_mid");
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
